// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
//
// Purpose : Shared encodings for the multicycle integer-datapath controller:
//           instruction opcode and func fields, ALU operation codes and the
//           sequencer state enum.
//
// Ports   : none (package only)
//
// Configuration : MULTICYCLE_BEQ_EN (consumed by the importing modules; the
//                 BEQ opcode and BRANCH state are always defined here).
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Primary opcode field (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type func field (IR[5:0])
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;

    // Sequencer states. ST_BRANCH is only reachable when BEQ is enabled.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB       = 4'd7,
        ST_BRANCH   = 4'd8
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//
// Purpose : Combinational instruction decoder. Maps an opcode/func pair onto
//           the ALU operation and the datapath selects the sequencer needs,
//           and flags whether the instruction is one we know how to execute.
//
// Ports   :
//   i_opcode       in   6  opcode field
//   i_func         in   6  func field (only meaningful for R-type)
//   o_alu_control  out  4  ALU operation code
//   o_shift        out  1  ALU A operand = shamt
//   o_alu_src      out  1  ALU B operand = immediate
//   o_reg_dst      out  1  write register = rd (R-type) instead of rt
//   o_valid        out  1  instruction is decodable
//
// Configuration : MULTICYCLE_BEQ_EN adds BEQ (SUB on two registers).
// -----------------------------------------------------------------------------
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output logic [3:0] o_alu_control,
    output logic       o_shift,
    output logic       o_alu_src,
    output logic       o_reg_dst,
    output logic       o_valid
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_shift       = 1'b0;
        o_alu_src     = 1'b0;
        o_reg_dst     = 1'b0;
        o_valid       = 1'b0;

        case (i_opcode)
            OP_RTYPE: begin
                o_reg_dst = 1'b1;
                case (i_func)
                    FN_ADD: begin o_alu_control = ALU_ADD; o_valid = 1'b1; end
                    FN_SUB: begin o_alu_control = ALU_SUB; o_valid = 1'b1; end
                    FN_AND: begin o_alu_control = ALU_AND; o_valid = 1'b1; end
                    FN_OR:  begin o_alu_control = ALU_OR;  o_valid = 1'b1; end
                    FN_XOR: begin o_alu_control = ALU_XOR; o_valid = 1'b1; end
                    FN_SLL: begin
                        o_alu_control = ALU_SLL;
                        o_shift       = 1'b1;
                        o_valid       = 1'b1;
                    end
                    FN_SRL: begin
                        o_alu_control = ALU_SRL;
                        o_shift       = 1'b1;
                        o_valid       = 1'b1;
                    end
                    default: o_valid = 1'b0;
                endcase
            end
            OP_ADDI: begin o_alu_control = ALU_ADD; o_alu_src = 1'b1; o_valid = 1'b1; end
            OP_ANDI: begin o_alu_control = ALU_AND; o_alu_src = 1'b1; o_valid = 1'b1; end
            OP_ORI:  begin o_alu_control = ALU_OR;  o_alu_src = 1'b1; o_valid = 1'b1; end
            OP_XORI: begin o_alu_control = ALU_XOR; o_alu_src = 1'b1; o_valid = 1'b1; end
            OP_LUI:  begin o_alu_control = ALU_LUI; o_alu_src = 1'b1; o_valid = 1'b1; end
            // Loads and stores compute base + offset.
            OP_LW:   begin o_alu_control = ALU_ADD; o_alu_src = 1'b1; o_valid = 1'b1; end
            OP_SW:   begin o_alu_control = ALU_ADD; o_alu_src = 1'b1; o_valid = 1'b1; end
`ifdef MULTICYCLE_BEQ_EN
            // Equality is tested by subtracting the two register operands.
            OP_BEQ:  begin o_alu_control = ALU_SUB; o_alu_src = 1'b0; o_valid = 1'b1; end
`endif
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose : Multicycle sequencer for the integer datapath. Steps every
//           instruction through FETCH, DECODE, EXEC / MEM_ADDR, MEM_RD /
//           MEM_WR and WB, driving the shared ALU, register file and the
//           single unified memory port.
//
// Memory handshake: in FETCH, MEM_RD and MEM_WR the controller holds
//           mem_req=1 with stable outputs; the access completes in the cycle
//           where mem_ready=1, and the FSM advances on that edge. mem_ready is
//           ignored in every other state.
//
// Ports   :
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous, active-high reset
//   Opcode       in   6  instruction-register opcode field
//   Func         in   6  instruction-register func field
//   mem_ready    in   1  memory completes the current access this cycle
//   mem_req      out  1  memory access request
//   IorD         out  1  memory address select: 0 = PC, 1 = ALU result
//   IRWrite      out  1  load instruction register
//   PCWrite      out  1  load PC+4
//   MemWrite     out  1  store on current access
//   RegWrite     out  1  register-file write
//   RegDst       out  1  write register select: 1 = rd, 0 = rt
//   ALUSrc       out  1  ALU B select: 1 = immediate
//   Shift        out  1  ALU A select: shamt
//   MemToReg     out  1  write-back data select: 1 = memory
//   ALUControl   out  4  ALU operation code
//   instr_done   out  1  pulse on the final cycle of each instruction
//   illegal      out  1  pulse on an undecodable instruction
//   o_dbg_state  out  4  current FSM state (debug/observability)
//   PCWriteCond  out  1  conditional PC load (only with MULTICYCLE_BEQ_EN)
//
// Configuration : MULTICYCLE_BEQ_EN adds the BEQ instruction, the BRANCH state
//                 and the PCWriteCond port. Undefined, opcode 000100 is illegal.
// -----------------------------------------------------------------------------
module multicycle_controller
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       Shift,
    output logic       MemToReg,
    output logic [3:0] ALUControl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] o_dbg_state
`ifdef MULTICYCLE_BEQ_EN
    ,
    output logic       PCWriteCond
`endif
);

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_opcode;
    logic [5:0] r_func;

    logic [5:0] w_opcode;
    logic [5:0] w_func;
    logic [3:0] w_alu_control;
    logic       w_shift;
    logic       w_alu_src;
    logic       w_reg_dst;
    logic       w_valid;
    logic       w_is_lw;
    logic       w_is_sw;

    // -------------------------------------------------------------------------
    // State register and instruction-field capture. The IR is loaded at the
    // end of FETCH, so DECODE sees the new fields live on Opcode/Func; they are
    // captured on the DECODE edge so later IR changes cannot disturb the rest
    // of the instruction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_opcode <= 6'd0;
            r_func   <= 6'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_opcode <= Opcode;
                r_func   <= Func;
            end
        end
    end

    // Decode the live IR while in DECODE, the captured copy afterwards.
    assign w_opcode = (r_state == ST_DECODE) ? Opcode : r_opcode;
    assign w_func   = (r_state == ST_DECODE) ? Func   : r_func;

    assign w_is_lw  = (w_opcode == OP_LW);
    assign w_is_sw  = (w_opcode == OP_SW);

    assign o_dbg_state = r_state;

    alu_decoder u_alu_decoder (
        .i_opcode      (w_opcode),
        .i_func        (w_func),
        .o_alu_control (w_alu_control),
        .o_shift       (w_shift),
        .o_alu_src     (w_alu_src),
        .o_reg_dst     (w_reg_dst),
        .o_valid       (w_valid)
    );

    // -------------------------------------------------------------------------
    // Next-state and output decode. Everything is held at zero while rst is
    // high so that no write enable can fire in the cycle being reset, even
    // when the FSM is still sitting in a requesting state.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        ALUSrc       = 1'b0;
        Shift        = 1'b0;
        MemToReg     = 1'b0;
        ALUControl   = ALU_ADD;
        instr_done   = 1'b0;
        illegal      = 1'b0;
`ifdef MULTICYCLE_BEQ_EN
        PCWriteCond  = 1'b0;
`endif

        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_FETCH;
                end

                ST_FETCH: begin
                    mem_req = 1'b1;
                    IorD    = 1'b0;
                    if (mem_ready) begin
                        IRWrite      = 1'b1;
                        PCWrite      = 1'b1;
                        w_next_state = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (!w_valid) begin
                        illegal      = 1'b1;
                        instr_done   = 1'b1;
                        w_next_state = ST_FETCH;
                    end else if (w_is_lw || w_is_sw) begin
                        w_next_state = ST_MEM_ADDR;
`ifdef MULTICYCLE_BEQ_EN
                    end else if (w_opcode == OP_BEQ) begin
                        w_next_state = ST_BRANCH;
`endif
                    end else begin
                        w_next_state = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    ALUControl   = w_alu_control;
                    ALUSrc       = w_alu_src;
                    Shift        = w_shift;
                    w_next_state = ST_WB;
                end

                // For LW/SW the decoder already yields ADD with the immediate
                // on B, i.e. the base+offset address computation.
                ST_MEM_ADDR: begin
                    ALUControl   = w_alu_control;
                    ALUSrc       = w_alu_src;
                    Shift        = w_shift;
                    w_next_state = w_is_lw ? ST_MEM_RD : ST_MEM_WR;
                end

                // ALU fields keep their address-phase values so the ALU
                // result (the address) stays valid while memory is busy.
                ST_MEM_RD: begin
                    mem_req    = 1'b1;
                    IorD       = 1'b1;
                    ALUControl = w_alu_control;
                    ALUSrc     = w_alu_src;
                    Shift      = w_shift;
                    if (mem_ready) begin
                        w_next_state = ST_WB;
                    end
                end

                // The store strobe is qualified by mem_ready so a waited
                // access still produces exactly one MemWrite cycle.
                ST_MEM_WR: begin
                    mem_req    = 1'b1;
                    IorD       = 1'b1;
                    ALUControl = w_alu_control;
                    ALUSrc     = w_alu_src;
                    Shift      = w_shift;
                    if (mem_ready) begin
                        MemWrite     = 1'b1;
                        instr_done   = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end

                ST_WB: begin
                    RegWrite     = 1'b1;
                    RegDst       = w_reg_dst;
                    MemToReg     = w_is_lw;
                    ALUControl   = w_alu_control;
                    ALUSrc       = w_alu_src;
                    Shift        = w_shift;
                    instr_done   = 1'b1;
                    w_next_state = ST_FETCH;
                end

`ifdef MULTICYCLE_BEQ_EN
                ST_BRANCH: begin
                    ALUControl   = w_alu_control;
                    ALUSrc       = 1'b0;
                    PCWriteCond  = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = ST_FETCH;
                end
`endif

                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencer for the CPU's integer datapath. It replaces per-instruction single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. Each step drives the shared ALU, register file and single unified memory port. It sits between the instruction register (opcode/func fields) and the datapath enables, and handshakes with memory via req/ready.

## Interface
Parameters:
- none (encodings come from the shared package)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Opcode  in  6  instruction-register opcode field
- Func  in  6  instruction-register func field
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC+4
- MemWrite  out  1  store on current access
- RegWrite  out  1  register-file write
- RegDst  out  1  write register select: 1 = rd, 0 = rt
- ALUSrc  out  1  ALU B select: 1 = immediate
- Shift  out  1  ALU A select: shamt
- MemToReg  out  1  write-back data select: 1 = memory
- ALUControl  out  4  ALU operation code
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse on an undecodable instruction

## Operation
- States:
  - IDLE goes to FETCH unconditionally.
  - FETCH goes to DECODE on mem_ready, otherwise it holds.
  - DECODE branches by instruction class:
    - R-type or ALU-immediate go to EXEC.
    - LW and SW go to MEM_ADDR.
    - Anything else goes to FETCH with illegal=1.
  - EXEC goes to WB.
  - MEM_ADDR goes to MEM_RD for LW, or MEM_WR for SW.
  - MEM_RD goes to WB on mem_ready.
  - MEM_WR goes to FETCH on mem_ready.
  - WB goes to FETCH.
- Decode:
  - R-type is Opcode 000000, with Func:
    - 100000 ADD = 0000
    - 100010 SUB = 0001
    - 100100 AND = 0010
    - 100101 OR = 0011
    - 100110 XOR = 0100
    - 000000 SLL = 0110, Shift=1
    - 000010 SRL = 0111, Shift=1
  - Any other R-type Func is illegal.
  - Immediates:
    - ADDI 001000 = 0000
    - ANDI 001100 = 0010
    - ORI 001101 = 0011
    - XORI 001110 = 0100
    - LUI 001111 = 0101
  - Memory: LW 100011 and SW 101011 use ADD (0000).
- Outputs are a Moore decode of the state register plus the latched Opcode/Func. The exceptions are IRWrite/PCWrite, which are FETCH & mem_ready.
- Per-state outputs:
  - FETCH: mem_req=1, IorD=0.
  - EXEC: ALUControl, ALUSrc (immediate types), Shift.
  - MEM_ADDR: ALUSrc=1, ALUControl=0000.
  - MEM_RD: mem_req=1, IorD=1.
  - MEM_WR: mem_req=1, IorD=1, MemWrite=1.
  - WB: RegWrite=1.
    - R-type: RegDst=1.
    - Immediates: RegDst=0.
    - LW: MemToReg=1.
- ALU fields (ALUControl, ALUSrc, Shift) hold their EXEC/MEM_ADDR values through WB. Opcode/Func are captured into an internal register in DECODE so that later IR changes are ignored.
- instr_done asserts in WB, in MEM_WR & mem_ready, and in DECODE when illegal.
- Every output not listed for a state is 0.

## Timing
- Reset: state=IDLE and all outputs 0. The first FETCH is in the second cycle after rst deasserts.
- Cycles with zero memory wait:
  - R-type and immediate: 4 (FETCH, DECODE, EXEC, WB).
  - LW: 5.
  - SW: 4.
  - Illegal: 2.
- Each cycle that mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle. While waiting, all outputs are held stable.
- mem_ready outside a requesting state is ignored.
- rst asserted mid-instruction returns to IDLE the next edge. No write enable may assert in that reset cycle.
- A write enable is never asserted for more than one cycle per instruction.

## Configuration
- MULTICYCLE_BEQ_EN defined:
  - Adds BEQ (Opcode 000100).
  - DECODE goes to BRANCH, which drives ALUControl=0001 (SUB), ALUSrc=0, and a `PCWriteCond` output =1.
  - BRANCH goes to FETCH with instr_done=1.
  - BEQ takes 3 cycles.
- Undefined: the `PCWriteCond` port is absent and Opcode 000100 is illegal.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode, func and ALUControl localparams;
  - the state enum.
- Sub-module `alu_decoder` is combinational. It maps latched Opcode/Func to {ALUControl, Shift, ALUSrc, RegDst, valid}, and the FSM uses `valid` for the illegal path.

## Test plan
- rst held 3 cycles, then released with mem_ready=1: all outputs 0 during reset; mem_req=1 two cycles after release.
- ADD (000000/100000), mem_ready=1: 4 cycles; WB has RegWrite=1, RegDst=1, ALUControl=0000; instr_done pulses once.
- LW (100011) with mem_ready low for 2 cycles in MEM_RD: 7 cycles; IorD=1 and mem_req=1 held for 3 cycles; WB has MemToReg=1, RegDst=0.
- SW (101011): MemWrite=1 only in the MEM_WR cycle with mem_ready=1; RegWrite is never asserted.
- Opcode 111111, then R-type Func 111111: each gives illegal=1 in DECODE, returns to FETCH, and asserts no write enables.
- rst asserted during an LW's MEM_RD: next state is IDLE; RegWrite stays 0.
